hist_equalizer: RTL and testbench
=================================

// Module: hist_equalizer
// PURPOSE
//  Downstream of the histogram stage. Loads the 256-bin cumulative histogram (CDF) at frame end.
//  Builds a normalised equalisation LUT: lut[i] = ((cdf[i]-cdf_min)*255)/(total-cdf_min).
//  Remaps the live grey pixel stream through that LUT.
//  LUT is double-buffered: a LUT built during frame N is applied from the first frame start after the build completes.
// PARAMETERS
//  PIX_W  8    grey pixel / LUT entry width
//  BINS   256  histogram bins; equals 2**PIX_W
//  CUM_W  20   CDF value width
// PORTS
//  iPclk       in   1      pixel clock; the only clock
//  iRst        in   1      synchronous, active-high reset
//  iFval       in   1      frame valid
//  iDval       in   1      pixel data valid
//  iGrey       in   PIX_W  input grey pixel
//  iCum_wr     in   1      CDF write strobe
//  iCum_addr   in   PIX_W  CDF bin index; strictly ascending 0..BINS-1 per load
//  iCum_data   in   CUM_W  CDF value for bin iCum_addr
//  oGrey_eq    out  PIX_W  equalised pixel
//  oDval       out  1      iDval delayed to align with oGrey_eq
//  oFval       out  1      iFval delayed to align with oGrey_eq
//  oLut_valid  out  1      high once any built LUT is active
//  oBusy       out  1      high in LOAD/PREP/DIV
//  oDrop       out  1      1-cycle pulse when a CDF write is ignored
// BEHAVIOUR
//  Reset values: every output 0, FSM in IDLE, active LUT = identity, pending = 0, cdf_min = 0.
//  Datapath:
//   - Synchronous LUT read of iGrey, then output register; oGrey_eq/oDval/oFval lag inputs by exactly 2 cycles.
//   - Before the first swap, or with oLut_valid=0, output = input (identity LUT).
//  FSM:
//   - IDLE: iCum_wr with addr 0 -> LOAD.
//     iCum_wr with addr != 0 -> oDrop, stay in IDLE.
//   - LOAD: store data in cdf RAM. cdf_min = first nonzero value in ascending order.
//     The write with addr BINS-1 captures total = data -> PREP.
//     A non-ascending addr -> oDrop, discard load, return to IDLE.
//   - PREP (1 cycle): denom = total - cdf_min; bin index i = 0.
//   - DIV: per bin:
//       - read cdf[i];
//       - num = (cdf[i] < cdf_min) ? 0 : (cdf[i]-cdf_min)*255, width CUM_W+8;
//       - start divider, wait for done;
//       - write quotient saturated to 255 into shadow lut[i].
//     If denom == 0 (single-grey or empty frame), write lut[i] = i and skip the divider.
//     After i = BINS-1 -> READY; pending = 1.
//   - READY: on iFval rising edge, swap active/shadow, set oLut_valid = 1, clear pending -> IDLE.
//     iCum_wr addr 0 in READY: pending cleared, new LOAD starts, previous build discarded.
//  CDF writes during PREP/DIV are ignored and pulse oDrop once per write.
//  Swap happens only on an iFval rising edge, never mid-frame. The edge is detected on registered iFval.
//  Simultaneous iFval rise and build completion: the swap waits for the next frame.
//  iRst mid-build aborts; the active LUT reverts to identity.
//  Build time per bin is ≤ CUM_W+8+3 cycles, about 7.9k cycles per LUT.
// CONFIGURATION
//  `HISTEQ_BYPASS_EN`
//   - Defined: adds input port iBypass (1 bit), sampled on the iFval rising edge.
//     While the sampled value is 1, oGrey_eq = iGrey with the same 2-cycle latency.
//     LUT build continues unaffected.
//   - Undefined: no iBypass port; equalisation is always applied once oLut_valid = 1.
// STRUCTURE
//  Package histo_pkg: BINS, PIX_W, CUM_W, NUM_W = CUM_W+8, typedef heq_state_t {IDLE, LOAD, PREP, DIV, READY}.
//  Sub-module hist_div_seq: restoring unsigned divider, NUM_W-bit numerator / CUM_W-bit denominator.
//   - start/done handshake; quotient valid when done is high for 1 cycle.
//   - start is ignored while busy.
//  Memories (inferred): cdf RAM BINS x CUM_W; two LUT RAMs BINS x PIX_W with a bank-select register.
// TESTING
//  1. Reset, stream 0..255 with no load
//     -> oGrey_eq == iGrey delayed 2 cycles; oLut_valid = 0.
//  2. Load uniform CDF cdf[i]=(i+1)*10, total 2560, cdf_min 10; wait for READY; raise iFval
//     -> lut[i] = ((i)*10*255)/2550 = i; output equals input; oLut_valid = 1.
//  3. Load CDF with all pixels at grey 100 (cdf[i<100]=0, else 1000); swap
//     -> denom 0, identity LUT, no divider activity; oGrey_eq(100) = 100.
//  4. Load CDF with pixels only at bins 50 and 200 (500 each, total 1000)
//     -> lut[0..49] = 0, lut[50..199] = 0, lut[200..255] = 255.
//  5. Write addr 5 while in DIV, then write non-ascending addr during LOAD
//     -> oDrop pulses once each; second load aborted; FSM back in IDLE.
//  6. Assert iRst during DIV, then stream pixels
//     -> identity output, oBusy = 0, oLut_valid = 0; a completed build swaps only on the next iFval rise.

Source files
------------

// File: rtl/histo_pkg.sv
// Shared constants, state encodings and the LUT saturation helper for the
// histogram-equalisation slice.
package histo_pkg;

  localparam int PIX_W   = 8;
  localparam int BINS    = 2 ** PIX_W;
  localparam int CUM_W   = 20;
  localparam int NUM_W   = CUM_W + 8;
  localparam int LUT_MAX = BINS - 1;

  typedef enum logic [2:0] {IDLE, LOAD, PREP, DIV, READY} heq_state_t;

  // Per-bin sub-step inside DIV: operand ready, or waiting on the divider.
  typedef enum logic {BIN_CALC, BIN_WAIT} bin_phase_t;

  // Clamp a quotient to the largest representable LUT entry.
  function automatic logic [PIX_W-1:0] sat_pix(input logic [NUM_W-1:0] q);
    return (q > NUM_W'(LUT_MAX)) ? '1 : q[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/hist_div_seq.sv
// Restoring unsigned divider, one quotient bit per cycle.
// start is accepted only when idle; quo is valid while done is high (1 cycle).
module hist_div_seq
  import histo_pkg::*;
#(
  parameter int NW = NUM_W,
  parameter int DW = CUM_W
) (
  input  logic          iPclk,
  input  logic          iRst,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          done,
  output logic [NW-1:0] quo
);

  localparam int CNT_W = $clog2(NW + 1);

  logic             busy;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    rem_q;
  logic [DW-1:0]    den_q;
  logic [DW:0]      shifted;
  logic [DW:0]      diff;
  logic             fits;

  // Trial subtraction of the divisor from the partial remainder.
  always_comb begin
    shifted = {rem_q, quo[NW-1]};
    diff    = shifted - {1'b0, den_q};
    fits    = (shifted >= {1'b0, den_q});
  end

  // Iterate NW times, shifting the quotient bits in from the right.
  always_ff @(posedge iPclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (iRst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      quo   <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy  <= 1'b1;
          quo   <= num;
          rem_q <= '0;
          den_q <= den;
          cnt_q <= CNT_W'(NW);
        end
      end else begin
        if (fits) begin
          rem_q <= diff[DW-1:0];
          quo   <= {quo[NW-2:0], 1'b1};
        end else begin
          rem_q <= shifted[DW-1:0];
          quo   <= {quo[NW-2:0], 1'b0};
        end
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hist_equalizer.sv
// Histogram equaliser: loads a CDF, builds a normalised LUT into the shadow
// bank, and swaps it in on the next frame start. Pixels see a 2-cycle latency.
// Optional build macro HISTEQ_BYPASS_EN adds iBypass (sampled at frame start).
module hist_equalizer
  import histo_pkg::*;
(
  input  logic             iPclk,
  input  logic             iRst,
  input  logic             iFval,
  input  logic             iDval,
  input  logic [PIX_W-1:0] iGrey,
  input  logic             iCum_wr,
  input  logic [PIX_W-1:0] iCum_addr,
  input  logic [CUM_W-1:0] iCum_data,
`ifdef HISTEQ_BYPASS_EN
  input  logic             iBypass,
`endif
  output logic [PIX_W-1:0] oGrey_eq,
  output logic             oDval,
  output logic             oFval,
  output logic             oLut_valid,
  output logic             oBusy,
  output logic             oDrop
);

  heq_state_t       state;
  bin_phase_t       phase;
  logic [PIX_W-1:0] bin_idx, last_addr, rd_addr, lut_wd;
  logic [CUM_W-1:0] cdf_min, total, denom, cdf_q, excess;
  logic [NUM_W-1:0] div_num, div_quo;
  logic             min_found, pending, busy, drop, bank_sel, lut_valid;
  logic             div_start, div_done;
  logic             load_start, lut_we, fval_rise, use_lut;
  logic             fval_d1, dval_d1;
  logic [PIX_W-1:0] grey_d1, lut0_q, lut1_q;

  logic [CUM_W-1:0] cdf_ram [BINS];
  logic [PIX_W-1:0] lut0    [BINS];
  logic [PIX_W-1:0] lut1    [BINS];

  // Decode load starts, LUT writes and the read address feeding the next bin.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    lut_we     = 1'b0;
    lut_wd     = bin_idx;
    load_start = iCum_wr && (iCum_addr == '0) && (state == IDLE || state == READY);
    fval_rise  = iFval && !fval_d1;
    excess     = cdf_q - cdf_min;
    if (state == DIV) begin
      if (phase == BIN_CALC && denom == '0) begin
        lut_we = 1'b1;
      end else if (phase == BIN_WAIT && div_done) begin
        lut_we = 1'b1;
        lut_wd = sat_pix(div_quo);
      end
    end
    // Prefetch the next bin so its CDF value is ready the cycle after a write.
    if (state == PREP)  rd_addr = '0;
    else if (lut_we)    rd_addr = bin_idx + 1'b1;
    else                rd_addr = bin_idx;
  end

  hist_div_seq u_div (
    .iPclk (iPclk),
    .iRst  (iRst),
    .start (div_start),
    .num   (div_num),
    .den   (denom),
    .done  (div_done),
    .quo   (div_quo)
  );

  // Control FSM: CDF load, per-bin LUT build, and frame-aligned bank swap.
  always_ff @(posedge iPclk) begin
    if (iRst) begin
      state     <= IDLE;
      phase     <= BIN_CALC;
      bin_idx   <= '0;
      last_addr <= '0;
      cdf_min   <= '0;
      min_found <= 1'b0;
      total     <= '0;
      denom     <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      drop      <= 1'b0;
      div_start <= 1'b0;
      div_num   <= '0;
      bank_sel  <= 1'b0;
      lut_valid <= 1'b0;
    end else begin
      drop      <= 1'b0;
      div_start <= 1'b0;
      if (load_start) begin
        // A new load discards any finished-but-unswapped build.
        state     <= LOAD;
        busy      <= 1'b1;
        pending   <= 1'b0;
        last_addr <= '0;
        cdf_min   <= iCum_data;
        min_found <= (iCum_data != '0);
      end else begin
        unique case (state)
          IDLE: if (iCum_wr) drop <= 1'b1;
          LOAD: if (iCum_wr) begin
            if (iCum_addr > last_addr) begin
              last_addr <= iCum_addr;
              if (!min_found && iCum_data != '0) begin
                cdf_min   <= iCum_data;
                min_found <= 1'b1;
              end
              if (iCum_addr == PIX_W'(LUT_MAX)) begin
                total <= iCum_data;
                state <= PREP;
              end
            end else begin
              drop  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          PREP: begin
            if (iCum_wr) drop <= 1'b1;
            denom   <= total - cdf_min;
            bin_idx <= '0;
            phase   <= BIN_CALC;
            state   <= DIV;
          end
          DIV: begin
            if (iCum_wr) drop <= 1'b1;
            if (lut_we) begin
              phase <= BIN_CALC;
              if (bin_idx == PIX_W'(LUT_MAX)) begin
                state   <= READY;
                busy    <= 1'b0;
                pending <= 1'b1;
              end else begin
                bin_idx <= bin_idx + 1'b1;
              end
            end else if (phase == BIN_CALC) begin
              div_num   <= (cdf_q < cdf_min) ? '0 : NUM_W'(excess) * NUM_W'(LUT_MAX);
              div_start <= 1'b1;
              phase     <= BIN_WAIT;
            end
          end
          READY: begin
            if (iCum_wr) drop <= 1'b1;
            if (fval_rise) begin
              bank_sel  <= ~bank_sel;
              lut_valid <= 1'b1;
              pending   <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // CDF store and LUT banks; the shadow bank is the one not selected.
  always_ff @(posedge iPclk) begin
    // NOTE: memories carry no reset; lut_valid gates their contents instead.
    if (load_start || (iCum_wr && state == LOAD && iCum_addr > last_addr))
      cdf_ram[iCum_addr] <= iCum_data;
    cdf_q <= cdf_ram[rd_addr];
    if (lut_we && bank_sel)  lut0[bin_idx] <= lut_wd;
    if (lut_we && !bank_sel) lut1[bin_idx] <= lut_wd;
    lut0_q <= lut0[iGrey];
    lut1_q <= lut1[iGrey];
  end

`ifdef HISTEQ_BYPASS_EN
  logic bypass_q;

  // Bypass request is latched once per frame start.
  always_ff @(posedge iPclk) begin
    if (iRst)           bypass_q <= 1'b0;
    else if (fval_rise) bypass_q <= iBypass;
  end

  assign use_lut = lut_valid && !bypass_q;
`else
  assign use_lut = lut_valid;
`endif

  // Two-stage pixel pipeline: LUT read, then bank/identity select.
  always_ff @(posedge iPclk) begin
    if (iRst) begin
      fval_d1  <= 1'b0;
      dval_d1  <= 1'b0;
      grey_d1  <= '0;
      oGrey_eq <= '0;
      oDval    <= 1'b0;
      oFval    <= 1'b0;
    end else begin
      fval_d1  <= iFval;
      dval_d1  <= iDval;
      grey_d1  <= iGrey;
      oGrey_eq <= use_lut ? (bank_sel ? lut1_q : lut0_q) : grey_d1;
      oDval    <= dval_d1;
      oFval    <= fval_d1;
    end
  end

  assign oLut_valid = lut_valid;
  assign oBusy      = busy;
  assign oDrop      = drop;

endmodule

// File: tb/tb_hist_equalizer.sv
// Directed bench for hist_equalizer with a spec-level LUT model and a
// per-cycle output comparator.
module tb_hist_equalizer;

  logic        iPclk = 1'b0;
  logic        iRst  = 1'b1;
  logic        iFval = 1'b0;
  logic        iDval = 1'b0;
  logic [7:0]  iGrey = '0;
  logic        iCum_wr = 1'b0;
  logic [7:0]  iCum_addr = '0;
  logic [19:0] iCum_data = '0;
  logic [7:0]  oGrey_eq;
  logic        oDval, oFval, oLut_valid, oBusy, oDrop;
`ifdef HISTEQ_BYPASS_EN
  logic        iBypass = 1'b0;
`endif

  hist_equalizer dut (
    .iPclk      (iPclk),
    .iRst       (iRst),
    .iFval      (iFval),
    .iDval      (iDval),
    .iGrey      (iGrey),
    .iCum_wr    (iCum_wr),
    .iCum_addr  (iCum_addr),
    .iCum_data  (iCum_data),
`ifdef HISTEQ_BYPASS_EN
    .iBypass    (iBypass),
`endif
    .oGrey_eq   (oGrey_eq),
    .oDval      (oDval),
    .oFval      (oFval),
    .oLut_valid (oLut_valid),
    .oBusy      (oBusy),
    .oDrop      (oDrop)
  );

  always #5 iPclk = ~iPclk;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  bit chk_en = 0;

  // Model state: active LUT, freshly built LUT, and whether one awaits a frame start.
  int cdf_tab   [256];
  int model_lut [256];
  int shadow_lut[256];
  bit model_valid = 0;
  bit model_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Equalisation LUT straight from the normalisation formula.
  function automatic void build_model(input int total);
    longint cmin, denom, num, q;
    cmin = 0;
    for (int i = 0; i < 256; i++)
      if (cmin == 0 && cdf_tab[i] != 0) cmin = cdf_tab[i];
    denom = longint'(total) - cmin;
    for (int i = 0; i < 256; i++) begin
      if (denom == 0) shadow_lut[i] = i;
      else begin
        num = (cdf_tab[i] < cmin) ? 0 : (cdf_tab[i] - cmin) * 255;
        q = num / denom;
        shadow_lut[i] = (q > 255) ? 255 : int'(q);
      end
    end
  endfunction

  // Output comparator: every cycle, outputs must equal inputs of two edges ago.
  typedef struct { bit rst; bit fval; bit dval; int grey; } exp_t;
  exp_t prev, cur;
  bit   have_prev = 0;
  always @(posedge iPclk) begin
    cur.rst  = iRst;
    cur.fval = iFval;
    cur.dval = iDval;
    cur.grey = model_valid ? model_lut[iGrey] : int'(iGrey);
    #1;
    if (chk_en && have_prev && !prev.rst && !cur.rst) begin
      check("fval_pipe", oFval, prev.fval);
      check("dval_pipe", oDval, prev.dval);
      if (prev.dval) check("grey_pipe", oGrey_eq, prev.grey);
    end
    prev = cur;
    have_prev = 1;
  end

  always @(posedge iPclk) begin
    #1;
    if (oDrop === 1'b1) drop_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input int n);
    @(negedge iPclk);
    iRst = 1; iCum_wr = 0; iDval = 0; iFval = 0;
    model_valid = 0; model_pending = 0;
    repeat (n) @(negedge iPclk);
    iRst = 0;
  endtask

  task automatic frame_begin();
    @(negedge iPclk); iFval = 0; iDval = 0;
    @(negedge iPclk);
    @(negedge iPclk); iFval = 1;
    if (model_pending) begin
      model_lut = shadow_lut;
      model_valid = 1;
      model_pending = 0;
    end
  endtask

  task automatic pixels(input int first, input int n, input int step);
    for (int k = 0; k < n; k++) begin
      @(negedge iPclk);
      iDval = 1;
      iGrey = 8'((first + k * step) & 255);
    end
    @(negedge iPclk); iDval = 0;
  endtask

  task automatic hit_pixel(input string name, input int g, input int exp);
    @(negedge iPclk); iDval = 1; iGrey = 8'(g);
    @(negedge iPclk); iDval = 0;
    @(posedge iPclk); #1;
    check(name, oGrey_eq, exp);
  endtask

  task automatic write_cdf(input int total);
    model_pending = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge iPclk);
      iCum_wr = 1; iCum_addr = 8'(i); iCum_data = 20'(cdf_tab[i]);
    end
    @(negedge iPclk); iCum_wr = 0;
    build_model(total);
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    do begin
      @(posedge iPclk); #1;
      cycles++;
    end while (oBusy !== 1'b0 && cycles < 10000);
    check("build_done", oBusy, 0);
    if (oBusy === 1'b0) model_pending = 1;
  endtask

  task automatic cum_write(input int addr, input int data);
    @(negedge iPclk);
    iCum_wr = 1; iCum_addr = 8'(addr); iCum_data = 20'(data);
  endtask

  initial begin
    int cyc, d0;
    // Reset state
    repeat (2) @(posedge iPclk);
    #1;
    check("rst_grey", oGrey_eq, 0);
    check("rst_dval", oDval, 0);
    check("rst_fval", oFval, 0);
    check("rst_lut_valid", oLut_valid, 0);
    check("rst_busy", oBusy, 0);
    check("rst_drop", oDrop, 0);
    @(negedge iPclk); iRst = 0;
    chk_en = 1;

    // 1: no LUT loaded -> identity
    frame_begin();
    pixels(0, 256, 1);
    check("t1_lut_valid", oLut_valid, 0);
    hit_pixel("t1_pix", 173, 173);

    // 2: uniform CDF -> identity LUT built by division
    for (int i = 0; i < 256; i++) cdf_tab[i] = (i + 1) * 10;
    write_cdf(2560);
    check("t2_model_200", shadow_lut[200], 200);
    wait_ready(cyc);
    check("t2_build_time_ok", (cyc <= 8000), 1);
    frame_begin();
    pixels(0, 256, 1);
    check("t2_lut_valid", oLut_valid, 1);
    hit_pixel("t2_pix", 77, 77);

    // 3: single grey level -> zero denominator, identity, no divider use
    for (int i = 0; i < 256; i++) cdf_tab[i] = (i < 100) ? 0 : 1000;
    write_cdf(1000);
    check("t3_model_100", shadow_lut[100], 100);
    wait_ready(cyc);
    check("t3_fast_build", (cyc < 600), 1);
    frame_begin();
    pixels(0, 256, 1);
    hit_pixel("t3_pix100", 100, 100);

    // 4: two populated bins -> hard 0 / 255 split
    for (int i = 0; i < 256; i++) cdf_tab[i] = (i < 50) ? 0 : (i < 200) ? 500 : 1000;
    write_cdf(1000);
    check("t4_model_199", shadow_lut[199], 0);
    check("t4_model_200", shadow_lut[200], 255);
    wait_ready(cyc);
    frame_begin();
    pixels(0, 256, 1);
    hit_pixel("t4_pix49", 49, 0);
    hit_pixel("t4_pix120", 120, 0);
    hit_pixel("t4_pix200", 200, 255);
    hit_pixel("t4_pix255", 255, 255);

    // 5: write during DIV, then non-ascending write aborts a reload
    for (int i = 0; i < 256; i++) cdf_tab[i] = (i + 1) * 10;
    write_cdf(2560);
    repeat (100) @(negedge iPclk);
    d0 = drop_cnt;
    cum_write(5, 123);
    @(negedge iPclk); iCum_wr = 0;
    repeat (3) @(negedge iPclk);
    check("t5_drop_div", drop_cnt - d0, 1);
    check("t5_busy_div", oBusy, 1);
    wait_ready(cyc);
    model_pending = 0;
    d0 = drop_cnt;
    cum_write(0, 7);
    cum_write(1, 8);
    cum_write(2, 9);
    cum_write(1, 10);
    @(negedge iPclk); iCum_wr = 0;
    repeat (3) @(negedge iPclk);
    check("t5_drop_abort", drop_cnt - d0, 1);
    check("t5_busy_abort", oBusy, 0);
    frame_begin();
    pixels(0, 256, 1);
    hit_pixel("t5_keep_old", 200, 255);

    // 6: reset mid-build, then a build finishing mid-frame waits for next frame
    for (int i = 0; i < 256; i++) cdf_tab[i] = (i < 50) ? 0 : (i < 200) ? 500 : 1000;
    write_cdf(1000);
    repeat (200) @(negedge iPclk);
    apply_reset(2);
    @(posedge iPclk); #1;
    check("t6_busy", oBusy, 0);
    check("t6_lut_valid", oLut_valid, 0);
    frame_begin();
    pixels(0, 256, 1);
    hit_pixel("t6_ident", 200, 200);
    write_cdf(1000);
    wait_ready(cyc);
    pixels(0, 64, 4);
    hit_pixel("t6_no_midframe_swap", 200, 200);
    frame_begin();
    pixels(0, 256, 1);
    hit_pixel("t6_swapped", 200, 255);
    check("t6_lut_valid_after", oLut_valid, 1);

    repeat (4) @(negedge iPclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
